ann_operand_loader: RTL and testbench

- Initiator/feeder for the neuron block's start/Ready interface.
- Accepts a byte stream: n input bytes, then n weight bytes, plus a bias. Packs them into the neuron's InputVec/WeightVec and issues a one-cycle start.
- Waits for the neuron's Ready, captures both 21-bit results and presents them downstream on a valid/ready handshake.
- Sits between the host/stimulus stream and one neuron instance.

---
 rtl/ann_operand_loader.sv | 135 +++++++++++++
 tb/tb_ann_operand_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ann_operand_loader.sv
// Loads a byte stream (n inputs, n weights, bias) into neuron operand vectors, pulses start, and returns the captured results on valid/ready.
// Latency: start the cycle after the last byte is accepted; res_valid the cycle after a qualifying Ready; upstream is stalled (in_ready=0) outside LOAD.
module ann_operand_loader #(
    parameter int n  = 62,
    parameter int CW = $clog2(2*n+1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [7:0]     bias_in,
    input  logic [7:0]     in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [0:8*n-1] InputVec,
    output logic [0:8*n-1] WeightVec,
    output logic [7:0]     bias,
    output logic           start,
    input  logic           ann_ready,
    input  logic [20:0]    ann_shifted,
    input  logic [20:0]    ann_raw,
    output logic [20:0]    res_shifted,
    output logic [20:0]    res_raw,
    output logic           res_valid,
    input  logic           res_ready,
    output logic           busy
);
    localparam logic [1:0] LOAD  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    localparam int          VW   = $clog2(8*n);
    localparam logic [CW-1:0] NB   = CW'(n);
    localparam logic [CW-1:0] LAST = CW'(2*n-1);

    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [0:8*n-1] in_vec_q, in_vec_d;
    logic [0:8*n-1] wt_vec_q, wt_vec_d;
    logic [7:0]     bias_q, bias_d;
    logic [20:0]    res_sh_q, res_sh_d;
    logic [20:0]    res_raw_q, res_raw_d;
    logic           res_vld_q, res_vld_d;
    logic           seen_low_q, seen_low_d;

    logic           accept;
    logic [CW-1:0]  slot;
    logic [VW-1:0]  bit_off;

    assign in_ready = rst_n && (state_q == LOAD);
    assign accept   = in_valid && in_ready;
    assign slot     = (count_q < NB) ? count_q : (count_q - NB);
    assign bit_off  = VW'(slot) << 3;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        in_vec_d   = in_vec_q;
        wt_vec_d   = wt_vec_q;
        bias_d     = bias_q;
        res_sh_d   = res_sh_q;
        res_raw_d  = res_raw_q;
        res_vld_d  = res_vld_q;
        seen_low_d = seen_low_q;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    if (count_q < NB) in_vec_d[bit_off +: 8] = in_data;
                    else              wt_vec_d[bit_off +: 8] = in_data;
                    if (count_q == '0) bias_d = bias_in;
                    if (count_q == LAST) begin
                        count_d = '0;
                        state_d = START;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            START: begin
                seen_low_d = 1'b0;
                state_d    = WAIT;
            end
            WAIT: begin
                // Ready must be seen low after start, so a stale high from the previous job is ignored.
                if (ann_ready && seen_low_q) begin
                    res_sh_d  = ann_shifted;
                    res_raw_d = ann_raw;
                    res_vld_d = 1'b1;
                    state_d   = HOLD;
                end else if (!ann_ready) begin
                    seen_low_d = 1'b1;
                end
            end
            HOLD: begin
                if (res_vld_q && res_ready) begin
                    res_vld_d = 1'b0;
                    state_d   = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD;
            count_q    <= '0;
            in_vec_q   <= '0;
            wt_vec_q   <= '0;
            bias_q     <= '0;
            res_sh_q   <= '0;
            res_raw_q  <= '0;
            res_vld_q  <= 1'b0;
            seen_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            in_vec_q   <= in_vec_d;
            wt_vec_q   <= wt_vec_d;
            bias_q     <= bias_d;
            res_sh_q   <= res_sh_d;
            res_raw_q  <= res_raw_d;
            res_vld_q  <= res_vld_d;
            seen_low_q <= seen_low_d;
        end
    end

    assign InputVec    = in_vec_q;
    assign WeightVec   = wt_vec_q;
    assign bias        = bias_q;
    assign start       = (state_q == START);
    assign res_shifted = res_sh_q;
    assign res_raw     = res_raw_q;
    assign res_valid   = res_vld_q;
    assign busy        = (state_q != LOAD);
endmodule

// File: tb/tb_ann_operand_loader.sv
// Directed bench: a small n=4 loader for handshake/stale-Ready/reset cases and a full n=62 loader for gapped streaming.
module tb_ann_operand_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] bias_in = '0;
    logic [7:0] in_data = '0;

    logic        in_valid4 = 1'b0, in_ready4, start4, busy4, res_valid4;
    logic        ann_ready4 = 1'b1, res_ready4 = 1'b0;
    logic [20:0] ann_sh4 = '0, ann_raw4 = '0, res_sh4, res_raw4;
    logic [0:31] in_vec4, wt_vec4;
    logic [7:0]  bias4;

    logic        in_valid62 = 1'b0, in_ready62, start62, busy62, res_valid62;
    logic        ann_ready62 = 1'b0, res_ready62 = 1'b0;
    logic [20:0] ann_sh62 = '0, ann_raw62 = '0, res_sh62, res_raw62;
    logic [0:495] in_vec62, wt_vec62, exp_in, exp_wt;
    logic [7:0]  bias62;

    int checks = 0;
    int errors = 0;
    int early_starts;
    logic [20:0] held_sh, held_raw;

    always #5 clk = ~clk;

    ann_operand_loader #(.n(4)) u4 (
        .clk(clk), .rst_n(rst_n), .bias_in(bias_in), .in_data(in_data),
        .in_valid(in_valid4), .in_ready(in_ready4), .InputVec(in_vec4), .WeightVec(wt_vec4),
        .bias(bias4), .start(start4), .ann_ready(ann_ready4), .ann_shifted(ann_sh4),
        .ann_raw(ann_raw4), .res_shifted(res_sh4), .res_raw(res_raw4), .res_valid(res_valid4),
        .res_ready(res_ready4), .busy(busy4)
    );

    ann_operand_loader #(.n(62)) u62 (
        .clk(clk), .rst_n(rst_n), .bias_in(bias_in), .in_data(in_data),
        .in_valid(in_valid62), .in_ready(in_ready62), .InputVec(in_vec62), .WeightVec(wt_vec62),
        .bias(bias62), .start(start62), .ann_ready(ann_ready62), .ann_shifted(ann_sh62),
        .ann_raw(ann_raw62), .res_shifted(res_sh62), .res_raw(res_raw62), .res_valid(res_valid62),
        .res_ready(res_ready62), .busy(busy62)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed 8 bytes back-to-back into the n=4 loader; bias only offered with byte 0.
    task automatic load4(input logic [63:0] bytes, input logic [7:0] b);
        logic [63:0] v;
        v = bytes;
        for (int i = 0; i < 8; i++) begin
            in_data   = v[63-8*i -: 8];
            bias_in   = (i == 0) ? b : 8'hEE;
            in_valid4 = 1'b1;
            tick();
        end
        in_valid4 = 1'b0;
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_in_ready", in_ready4, 0);
        chk("rst_start", start4, 0);
        chk("rst_res_valid", res_valid4, 0);
        chk("rst_vec", in_vec4, 0);
        chk("rst_busy", busy4, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready4, 1);

        // Basic load and start timing
        load4(64'h01020304_10203040, 8'h05);
        chk("t1_start", start4, 1);
        chk("t1_in_ready", in_ready4, 0);
        chk("t1_in_vec", in_vec4, 32'h01020304);
        chk("t1_wt_vec", wt_vec4, 32'h10203040);
        chk("t1_bias", bias4, 8'h05);
        ann_ready4 = 1'b0;
        tick();
        chk("t1_start_one_cycle", start4, 0);
        chk("t1_busy", busy4, 1);
        tick();
        tick();
        chk("t2_no_result_yet", res_valid4, 0);
        ann_ready4 = 1'b1;
        ann_sh4    = 21'h000ABC;
        ann_raw4   = 21'h155780;
        tick();
        chk("t2_res_valid", res_valid4, 1);
        chk("t2_res_sh", res_sh4, 21'h000ABC);
        chk("t2_res_raw", res_raw4, 21'h155780);

        // Held result with stalled consumer and an offered byte
        ann_sh4   = 21'h1F0F0F;
        ann_raw4  = 21'h0F0F0F;
        in_valid4 = 1'b1;
        in_data   = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_in_ready", in_ready4, 0);
            chk("t4_res_valid", res_valid4, 1);
            chk("t4_res_sh_stable", res_sh4, 21'h000ABC);
        end
        chk("t4_res_raw_stable", res_raw4, 21'h155780);
        chk("t4_in_vec_stable", in_vec4, 32'h01020304);
        chk("t4_wt_vec_stable", wt_vec4, 32'h10203040);
        res_ready4 = 1'b1;
        tick();
        in_valid4 = 1'b0;
        res_ready4 = 1'b0;
        chk("t4_consumed", res_valid4, 0);
        chk("t4_in_ready_back", in_ready4, 1);
        chk("t4_busy_clear", busy4, 0);

        // Stale high Ready must not be captured
        ann_ready4 = 1'b1;
        ann_sh4    = 21'h00DEAD;
        ann_raw4   = 21'h00BEEF;
        load4(64'hA1A2A3A4_B1B2B3B4, 8'h7F);
        chk("t3_in_vec", in_vec4, 32'hA1A2A3A4);
        chk("t3_wt_vec", wt_vec4, 32'hB1B2B3B4);
        chk("t3_bias_byte0_only", bias4, 8'h7F);
        tick();
        tick();
        chk("t3_stale_hi_1", res_valid4, 0);
        tick();
        chk("t3_stale_hi_2", res_valid4, 0);
        ann_ready4 = 1'b0;
        tick();
        chk("t3_low_cycle", res_valid4, 0);
        ann_ready4 = 1'b1;
        ann_sh4    = 21'h1FFFFF;
        ann_raw4   = 21'h000001;
        res_ready4 = 1'b1;
        tick();
        chk("t3_capture", res_valid4, 1);
        chk("t3_res_sh", res_sh4, 21'h1FFFFF);
        chk("t3_res_raw", res_raw4, 21'h000001);
        tick();
        res_ready4 = 1'b0;
        chk("t3_consumed", res_valid4, 0);

        // Reset in the middle of a load
        for (int i = 0; i < 6; i++) begin
            in_data   = 8'hC0 + 8'(i);
            bias_in   = 8'h33;
            in_valid4 = 1'b1;
            tick();
        end
        in_valid4 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_in_vec_zero", in_vec4, 0);
        chk("t5_wt_vec_zero", wt_vec4, 0);
        chk("t5_bias_zero", bias4, 0);
        chk("t5_res_sh_zero", res_sh4, 0);
        chk("t5_res_raw_zero", res_raw4, 0);
        chk("t5_busy_zero", busy4, 0);
        chk("t5_in_ready_zero", in_ready4, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("t5_in_ready_release", in_ready4, 1);
        load4(64'h11121314_15161718, 8'h44);
        chk("t5_start", start4, 1);
        chk("t5_in_vec", in_vec4, 32'h11121314);
        chk("t5_wt_vec", wt_vec4, 32'h15161718);
        chk("t5_bias", bias4, 8'h44);
        // Reset during START must drop start at once
        rst_n = 1'b0;
        #1;
        chk("t5_start_drop", start4, 0);
        chk("t5_busy_drop", busy4, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Full n=62 load with in_valid toggling every other cycle
        early_starts = 0;
        for (int i = 0; i < 124; i++) begin
            in_data    = 8'(i + 1);
            bias_in    = 8'h9C;
            in_valid62 = 1'b1;
            tick();
            if (i < 123) begin
                if (start62) early_starts++;
                in_valid62 = 1'b0;
                tick();
                if (start62) early_starts++;
            end
        end
        in_valid62 = 1'b0;
        chk("t6_no_early_start", early_starts, 0);
        chk("t6_start", start62, 1);
        for (int k = 0; k < 62; k++) begin
            exp_in[8*k +: 8] = 8'(k + 1);
            exp_wt[8*k +: 8] = 8'(k + 63);
        end
        chk("t6_in_first", in_vec62[0:7], 8'd1);
        chk("t6_in_b61", in_vec62[488:495], 8'd62);
        chk("t6_wt_b62", wt_vec62[0:7], 8'd63);
        chk("t6_wt_last", wt_vec62[488:495], 8'd124);
        chk("t6_in_full", in_vec62, exp_in);
        chk("t6_wt_full", wt_vec62, exp_wt);
        chk("t6_bias", bias62, 8'h9C);
        tick();
        chk("t6_start_once", start62, 0);
        chk("t6_busy", busy62, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
